// File: rtl/lcd1602_bus_sched.sv
// Round-robin two-port write scheduler and RS/DATA/EN bus sequencer for an HD44780 1602 LCD.
// Build option: define LCD_SCHED_INIT_EN to sequence the built-in init ROM after power-up.
module lcd1602_bus_sched #(
  parameter int T_PWRUP = 1_080_000,
  parameter int T_AS    = 2,
  parameter int T_PW    = 13,
  parameter int T_H     = 1,
  parameter int T_SHORT = 1_080,
  parameter int T_LONG  = 44_280
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(max2(T_PWRUP, T_AS), max2(T_PW, T_H)), max2(T_SHORT, T_LONG));
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_EXEC  = 3'd5;

  function automatic logic [CW-1:0] ld(input int t);
    return CW'(t - 1);
  endfunction

  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

`ifdef LCD_SCHED_INIT_EN
  function automatic logic [7:0] rom(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  logic [1:0] idx_q, idx_d;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          gnt0, gnt1;

  // Port 0 wins a tie unless it was the most recent grant.
  assign gnt0       = req0_valid && (!req1_valid || last_q);
  assign gnt1       = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = (state_q == ST_IDLE) && done_q && gnt0;
  assign req1_ready = (state_q == ST_IDLE) && done_q && gnt1;

  assign init_done = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign LCD_DATA  = data_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = en_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    last_d  = last_q;
    done_d  = done_q;
`ifdef LCD_SCHED_INIT_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == '0) begin
`ifdef LCD_SCHED_INIT_EN
          // Init bytes are issued straight from the exit edge so they keep the write cadence.
          state_d = ST_SETUP;
          cnt_d   = ld(T_AS);
          data_d  = rom(2'd0);
          rs_d    = 1'b0;
          idx_d   = 2'd0;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = ST_SETUP;
          cnt_d   = ld(T_AS);
          rs_d    = req1_ready ? req1_rs : req0_rs;
          data_d  = req1_ready ? req1_data : req0_data;
          last_d  = req1_ready;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = ld(T_PW);
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = ld(T_H);
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_EXEC;
          cnt_d   = is_long(rs_q, data_q) ? ld(T_LONG) : ld(T_SHORT);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
`ifdef LCD_SCHED_INIT_EN
          if (!done_q && idx_q != 2'd3) begin
            state_d = ST_SETUP;
            cnt_d   = ld(T_AS);
            idx_d   = idx_q + 2'd1;
            data_d  = rom(idx_q + 2'd1);
            rs_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = ld(T_PWRUP);
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q <= ST_PWRUP;
      cnt_q   <= ld(T_PWRUP);
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef LCD_SCHED_INIT_EN
      idx_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef LCD_SCHED_INIT_EN
      idx_q   <= idx_d;
`endif
    end
  end

endmodule
